// File: rtl/tqv_periph_bus_ctrl_if.sv
// Core-side bus of the peripheral controller: address, write data, size
// strobes going in; read data and the completion pulse coming back.
//
// Handshake: a request is present while data_read_n != 2'b11 or
// data_write_n != 2'b11. The master holds addr, data_in and both strobes
// stable until it sees data_ready=1, and drops the request (both strobes
// back to 2'b11) in the cycle after that pulse. data_ready is high for
// exactly one cycle per request and data_out is meaningful only in that
// cycle. If both strobes are active the write wins.
interface tqv_periph_bus_ctrl_if;
  logic [8:0]  addr;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    output addr,
    output data_in,
    output data_write_n,
    output data_read_n,
    input  data_out,
    input  data_ready
  );

  modport slave (
    input  addr,
    input  data_in,
    input  data_write_n,
    input  data_read_n,
    output data_out,
    output data_ready
  );
endinterface

// File: rtl/tqv_periph_bus_ctrl.sv
// Peripheral bus controller: routes one core access at a time either to
// one of the peripheral slots (with a ready wait and a timeout) or to the
// small internal register block (interrupts, output mux, status).
module tqv_periph_bus_ctrl #(
  parameter int NUM_PERIPH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  tqv_periph_bus_ctrl_if.slave     bus,
  output logic [5:0]               per_address,
  output logic [31:0]              per_data_in,
  output logic [2*NUM_PERIPH-1:0]  per_write_n,
  output logic [2*NUM_PERIPH-1:0]  per_read_n,
  input  logic [32*NUM_PERIPH-1:0] per_data_out,
  input  logic [NUM_PERIPH-1:0]    per_data_ready,
  input  logic [NUM_PERIPH-1:0]    per_irq,
  input  logic [8*NUM_PERIPH-1:0]  per_uo_out,
  output logic [7:0]               uo_out,
  output logic                     irq,
  output logic [1:0]               dbg_state
);

  localparam int          IRQ_W     = NUM_PERIPH + 1;
  localparam logic [1:0]  SIZE_NONE = 2'b11;
  localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT_CYCLES - 1);

  // Internal register word offsets (addr[3:0] with addr[8]=1).
  localparam logic [3:0]  OFF_PEND   = 4'h0;
  localparam logic [3:0]  OFF_EN     = 4'h4;
  localparam logic [3:0]  OFF_UOSEL  = 4'h8;
  localparam logic [3:0]  OFF_STATUS = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Transaction state
  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [5:0]        off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              is_wr_q, is_wr_d;
  logic [1:0]        tgt_q, tgt_d;
  logic [31:0]       rdata_q, rdata_d;

  // Register block
  logic [IRQ_W-1:0]  pend_q, pend_d;
  logic [IRQ_W-1:0]  en_q, en_d;
  logic [1:0]        uo_sel_q, uo_sel_d;
  logic              st_to_q, st_to_d;
  logic [1:0]        st_idx_q, st_idx_d;

  // Decoded request and helpers
  logic              req;
  logic              req_wr;
  logic              reg_wr;
  logic              to_evt;
  logic              tgt_ready;
  logic [31:0]       tgt_rdata;
  logic [31:0]       reg_rdata;

  assign req_wr    = (bus.data_write_n != SIZE_NONE);
  assign req       = req_wr || (bus.data_read_n != SIZE_NONE);
  assign tgt_ready = per_data_ready[tgt_q];
  assign tgt_rdata = per_data_out[{tgt_q, 5'b00000} +: 32];

  // Register read mux, sampled at the accepting edge of an internal read.
  always_comb begin
    reg_rdata = 32'h0;
    case (bus.addr[3:0])
      OFF_PEND:   reg_rdata = 32'(pend_q);
      OFF_EN:     reg_rdata = 32'(en_q);
      OFF_UOSEL:  reg_rdata = 32'(uo_sel_q);
      OFF_STATUS: reg_rdata = {29'h0, st_idx_q, st_to_q};
      default:    reg_rdata = 32'h0;
    endcase
  end

  // Transaction FSM: accept, wait for the slot (or time out), report.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    is_wr_d = is_wr_q;
    tgt_d   = tgt_q;
    rdata_d = rdata_q;
    reg_wr  = 1'b0;
    to_evt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          off_d   = bus.addr[5:0];
          wdata_d = bus.data_in;
          is_wr_d = req_wr;
          size_d  = req_wr ? bus.data_write_n : bus.data_read_n;
          tgt_d   = bus.addr[7:6];
          if (bus.addr[8]) begin
            // Internal registers complete without a wait; the write lands now.
            reg_wr  = req_wr;
            rdata_d = req_wr ? 32'h0 : reg_rdata;
            state_d = ST_DONE;
          end else begin
            cnt_d   = 8'h0;
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        // Ready on the last counted cycle still counts as success.
        if (tgt_ready) begin
          rdata_d = is_wr_q ? 32'h0 : tgt_rdata;
          state_d = ST_DONE;
        end else if (cnt_q == TO_LAST) begin
          rdata_d = 32'h0;
          to_evt  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register block next state; a hardware set beats a W1C clear.
  always_comb begin
    logic [IRQ_W-1:0] pend_clr;
    logic             st_clr;
    pend_clr = '0;
    st_clr   = 1'b0;
    en_d     = en_q;
    uo_sel_d = uo_sel_q;
    st_idx_d = st_idx_q;
    if (reg_wr) begin
      case (bus.addr[3:0])
        OFF_PEND:   pend_clr = bus.data_in[IRQ_W-1:0];
        OFF_EN:     en_d     = bus.data_in[IRQ_W-1:0];
        OFF_UOSEL:  uo_sel_d = bus.data_in[1:0];
        OFF_STATUS: st_clr   = bus.data_in[0];
        default:    ;
      endcase
    end
    pend_d  = (pend_q & ~pend_clr) | {to_evt, per_irq};
    st_to_d = (st_to_q & ~st_clr) | to_evt;
    if (to_evt) begin
      st_idx_d = tgt_q;
    end
  end

  // Peripheral strobes: only the target slot, write for one cycle only.
  always_comb begin
    per_write_n = '1;
    per_read_n  = '1;
    if (state_q == ST_ACCESS) begin
      if (is_wr_q) begin
        if (cnt_q == 8'h0) begin
          per_write_n[{tgt_q, 1'b0} +: 2] = size_q;
        end
      end else begin
        per_read_n[{tgt_q, 1'b0} +: 2] = size_q;
      end
    end
  end

  assign per_address    = off_q;
  assign per_data_in    = wdata_q;
  assign bus.data_ready = (state_q == ST_DONE);
  assign bus.data_out   = (state_q == ST_DONE) ? rdata_q : 32'h0;
  assign uo_out         = per_uo_out[{uo_sel_q, 3'b000} +: 8];
  assign irq            = |(pend_q & en_q);
  assign dbg_state      = state_q;

  // State register; reset wins over everything, including a live access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'h0;
      off_q    <= 6'h0;
      wdata_q  <= 32'h0;
      size_q   <= SIZE_NONE;
      is_wr_q  <= 1'b0;
      tgt_q    <= 2'h0;
      rdata_q  <= 32'h0;
      pend_q   <= '0;
      en_q     <= '0;
      uo_sel_q <= 2'h0;
      st_to_q  <= 1'b0;
      st_idx_q <= 2'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      is_wr_q  <= is_wr_d;
      tgt_q    <= tgt_d;
      rdata_q  <= rdata_d;
      pend_q   <= pend_d;
      en_q     <= en_d;
      uo_sel_q <= uo_sel_d;
      st_to_q  <= st_to_d;
      st_idx_q <= st_idx_d;
    end
  end

endmodule
